// File: rtl/cache_bus_pkg.sv
// Shared definitions for the D-cache core bus: request-tag fields, responder states and address-field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_bus_pkg;

    // Request tag layout: {READ/WRITE, MEMORY/IO, DATA/INSN, 7'b0}
    localparam int TAG_W      = 10;
    localparam int TAG_RW_BIT = 9;
    localparam int TAG_MI_BIT = 8;
    localparam int TAG_DI_BIT = 7;

    localparam logic READ   = 1'b1;
    localparam logic WRITE  = 1'b0;
    localparam logic MEMORY = 1'b1;
    localparam logic IO     = 1'b0;
    localparam logic DATA   = 1'b1;
    localparam logic INSN   = 1'b0;

    // Every line fill is a data read from memory space.
    localparam logic [TAG_W-1:0] FILL_TAG = {READ, MEMORY, DATA, 7'b0};

    // Low address bits select a byte within a 64-bit word; they are ignored.
    localparam int BYTE_BITS = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        FILL,
        RESPOND
    } cacheState_t;

    function automatic int wordBits(input int lineWords);
        return $clog2(lineWords);
    endfunction

    function automatic int indexBits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagBits(input int sets, input int lineWords);
        return 64 - BYTE_BITS - $clog2(lineWords) - $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line storage for the D-cache: SETS x LINE_WORDS x 64-bit words, one synchronous write port, one combinational read port.
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: none; the write port accepts a word every cycle.
//
// Ports: clk; wrEn/wrIdx/wrWord/wrData write one word; rdIdx/rdWord select the word on rdData.
module dcache_data_array
    import cache_bus_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          wrEn,
    input  logic [indexBits(SETS)-1:0]    wrIdx,
    input  logic [wordBits(LINE_WORDS)-1:0] wrWord,
    input  logic [63:0]                   wrData,
    input  logic [indexBits(SETS)-1:0]    rdIdx,
    input  logic [wordBits(LINE_WORDS)-1:0] rdWord,
    output logic [63:0]                   rdData
);

    logic [63:0] store [SETS*LINE_WORDS];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            store[{wrIdx, wrWord}] <= wrData;
        end
    end

    assign rdData = store[{rdIdx, rdWord}];

endmodule

// File: rtl/dcache_responder.sv
// Core-facing responder of a direct-mapped read-only D-cache; misses fill a whole line from the memory bus.
// Latency: hit = ack one cycle after request, response the cycle after; miss adds fill request + LINE_WORDS beats.
// Backpressure: one request in flight; new requests are not acked until the response is consumed.
//
// Ports:
//   clk, reset (synchronous, active low)
//   core_reqcyc/core_req/core_reqtag in, core_reqack out      : core request handshake
//   core_respcyc/core_resp out, core_respack in               : core response handshake
//   mem_reqcyc/mem_req/mem_reqtag out, mem_reqack in          : line-fill request
//   mem_respcyc/mem_resp in, mem_respack out                  : fill beats, ascending word order
module dcache_responder
    import cache_bus_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             core_reqcyc,
    input  logic [63:0]      core_req,
    input  logic [TAG_W-1:0] core_reqtag,
    output logic             core_reqack,
    output logic             core_respcyc,
    output logic [63:0]      core_resp,
    input  logic             core_respack,
    output logic             mem_reqcyc,
    output logic [63:0]      mem_req,
    output logic [TAG_W-1:0] mem_reqtag,
    input  logic             mem_reqack,
    input  logic             mem_respcyc,
    input  logic [63:0]      mem_resp,
    output logic             mem_respack
);

    localparam int WORD_W = wordBits(LINE_WORDS);
    localparam int IDX_W  = indexBits(SETS);
    localparam int TAGF_W = tagBits(SETS, LINE_WORDS);
    localparam int LINE_LSB = BYTE_BITS + WORD_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    cacheState_t state, nextState;

    logic [63:BYTE_BITS]  reqAddr;
    logic [WORD_W-1:0]    reqWord;
    logic [IDX_W-1:0]     reqIdx;
    logic [TAGF_W-1:0]    reqTagF;

    logic [SETS-1:0]      valid;
    logic [TAGF_W-1:0]    tagMem [SETS];
    logic [WORD_W-1:0]    beatCnt;
    logic [63:0]          respData;
    logic                 memRespAck;
    logic [63:0]          rdData;
    logic                 hit;
    logic                 beatWe;
    logic                 fillLast;
    logic                 unusedBits;

    assign reqWord = reqAddr[BYTE_BITS +: WORD_W];
    assign reqIdx  = reqAddr[LINE_LSB +: IDX_W];
    assign reqTagF = reqAddr[63 -: TAGF_W];

    assign hit      = valid[reqIdx] && (tagMem[reqIdx] == reqTagF);
    assign beatWe   = reset && (state == FILL) && mem_respcyc;
    assign fillLast = beatWe && (beatCnt == LAST_BEAT);

    // Byte offset and the non-RW tag bits carry no meaning for a read-only cache.
    assign unusedBits = ^{core_req[BYTE_BITS-1:0], core_reqtag};

    dcache_data_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) dataArray (
        .clk    (clk),
        .wrEn   (beatWe),
        .wrIdx  (reqIdx),
        .wrWord (beatCnt),
        .wrData (mem_resp),
        .rdIdx  (reqIdx),
        .rdWord (reqWord),
        .rdData (rdData)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        core_reqack  = 1'b0;
        core_respcyc = 1'b0;
        mem_reqcyc   = 1'b0;
        case (state)
            IDLE:     if (core_reqcyc) nextState = LOOKUP;
            LOOKUP: begin
                core_reqack = 1'b1;
                nextState   = hit ? RESPOND : MISS_REQ;
            end
            MISS_REQ: begin
                mem_reqcyc = 1'b1;
                if (mem_reqack) nextState = FILL;
            end
            FILL:     if (fillLast) nextState = RESPOND;
            RESPOND: begin
                core_respcyc = 1'b1;
                if (core_respack) nextState = IDLE;
            end
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reqAddr    <= '0;
            valid      <= '0;
            beatCnt    <= '0;
            respData   <= '0;
            memRespAck <= 1'b0;
        end else begin
            memRespAck <= 1'b0;
            case (state)
                IDLE:    if (core_reqcyc) reqAddr <= core_req[63:BYTE_BITS];
                LOOKUP:  if (hit) respData <= rdData;
                FILL: begin
                    if (mem_respcyc) begin
                        // The requested word is taken straight off the bus; the array
                        // write for this beat is not visible until the next cycle.
                        if (beatCnt == reqWord) respData <= mem_resp;
                        if (beatCnt == LAST_BEAT) begin
                            valid[reqIdx] <= 1'b1;
                            beatCnt       <= '0;
                            memRespAck    <= 1'b1;
                        end else begin
                            beatCnt <= beatCnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fillLast) begin
            tagMem[reqIdx] <= reqTagF;
        end
    end

    assign core_resp   = respData;
    assign mem_req     = mem_reqcyc ? {reqAddr[63:LINE_LSB], {LINE_LSB{1'b0}}} : '0;
    assign mem_reqtag  = mem_reqcyc ? FILL_TAG : '0;
    assign mem_respack = memRespAck;

    always @(posedge clk) begin
        if (reset && state == IDLE && core_reqcyc) begin
            assert (core_reqtag[TAG_RW_BIT] == READ)
                else $fatal(1, "dcache_responder: non-read request accepted");
        end
        if (reset && state != FILL) begin
            assert (!mem_respcyc)
                else $fatal(1, "dcache_responder: fill beat outside a fill");
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;
    import cache_bus_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             core_reqcyc = 1'b0;
    logic [63:0]      core_req = '0;
    logic [TAG_W-1:0] core_reqtag = 10'h380;
    logic             core_reqack;
    logic             core_respcyc;
    logic [63:0]      core_resp;
    logic             core_respack = 1'b0;
    logic             mem_reqcyc;
    logic [63:0]      mem_req;
    logic [TAG_W-1:0] mem_reqtag;
    logic             mem_reqack = 1'b0;
    logic             mem_respcyc = 1'b0;
    logic [63:0]      mem_resp = '0;
    logic             mem_respack;

    int vectors = 0;
    int miscompares = 0;

    dcache_responder #(.SETS(64), .LINE_WORDS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_reqcyc  (core_reqcyc),
        .core_req     (core_req),
        .core_reqtag  (core_reqtag),
        .core_reqack  (core_reqack),
        .core_respcyc (core_respcyc),
        .core_resp    (core_resp),
        .core_respack (core_respack),
        .mem_reqcyc   (mem_reqcyc),
        .mem_req      (mem_req),
        .mem_reqtag   (mem_reqtag),
        .mem_reqack   (mem_reqack),
        .mem_respcyc  (mem_respcyc),
        .mem_resp     (mem_resp),
        .mem_respack  (mem_respack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Present a read and hold it until acked; cyc = cycles from request to ack seen.
    task automatic startRead(input logic [63:0] addr, output int cyc);
        @(negedge clk);
        core_req = addr;
        core_reqcyc = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (core_reqack !== 1'b1 && cyc < 20);
        core_reqcyc = 1'b0;
    endtask

    // Wait for the response, consume it. cyc = extra cycles waited.
    task automatic finishResp(output logic [63:0] data, output int cyc);
        cyc = 0;
        while (core_respcyc !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        data = core_resp;
        core_respack = 1'b1;
        @(negedge clk);
        core_respack = 1'b0;
    endtask

    // Memory model: accept a fill request after ackDelay cycles, then send nBeats beats
    // of value base+i, inserting one idle cycle before beat i when gapMask[i] is set.
    task automatic serveFill(input logic [7:0] base, input int ackDelay, input logic [7:0] gapMask,
                             input int nBeats, output logic [63:0] gotReq, output logic [9:0] gotTag,
                             output logic handshakeOk, output logic earlyDone,
                             output logic ackPulse, output logic ackAfter);
        int n;
        n = 0;
        handshakeOk = 1'b1;
        earlyDone = 1'b0;
        ackPulse = 1'b0;
        ackAfter = 1'b0;
        while (mem_reqcyc !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        gotReq = mem_req;
        gotTag = mem_reqtag;
        for (int i = 0; i < ackDelay; i++) begin
            @(negedge clk);
            if (mem_reqcyc !== 1'b1 || mem_req !== gotReq) handshakeOk = 1'b0;
        end
        mem_reqack = 1'b1;
        @(negedge clk);
        mem_reqack = 1'b0;
        if (mem_reqcyc !== 1'b0) handshakeOk = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            if (gapMask[i]) @(negedge clk);
            if (core_respcyc !== 1'b0) begin
                earlyDone = 1'b1;
                break;
            end
            mem_respcyc = 1'b1;
            mem_resp = 64'(base) + 64'(i);
            @(negedge clk);
            mem_respcyc = 1'b0;
            mem_resp = '0;
        end
        if (nBeats == 8 && !earlyDone) begin
            ackPulse = mem_respack;
            @(negedge clk);
            ackAfter = (mem_respack === 1'b0);
        end
    endtask

    task automatic test_reset;
        core_reqcyc = 1'b1;
        core_req = 64'h1008;
        repeat (3) @(negedge clk);
        vectors++; if (core_reqack !== 1'b0) begin miscompares++; $display("FAIL reset_reqack: got %b want 0", core_reqack); end
        vectors++; if (core_respcyc !== 1'b0) begin miscompares++; $display("FAIL reset_respcyc: got %b want 0", core_respcyc); end
        vectors++; if (core_resp !== 64'h0) begin miscompares++; $display("FAIL reset_resp: got %h want 0", core_resp); end
        vectors++; if (mem_reqcyc !== 1'b0) begin miscompares++; $display("FAIL reset_mem_reqcyc: got %b want 0", mem_reqcyc); end
        vectors++; if (mem_req !== 64'h0) begin miscompares++; $display("FAIL reset_mem_req: got %h want 0", mem_req); end
        vectors++; if (mem_reqtag !== 10'h0) begin miscompares++; $display("FAIL reset_mem_reqtag: got %h want 0", mem_reqtag); end
        vectors++; if (mem_respack !== 1'b0) begin miscompares++; $display("FAIL reset_mem_respack: got %b want 0", mem_respack); end
        core_reqcyc = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_miss;
        int cyc;
        logic [63:0] rq, data;
        logic [9:0] tg;
        logic hsOk, early, ap, aa;
        startRead(64'h1008, cyc);
        vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL cold_reqack_latency: got %0d want 1", cyc); end
        @(negedge clk);
        vectors++; if (mem_reqcyc !== 1'b1) begin miscompares++; $display("FAIL cold_mem_reqcyc: got %b want 1", mem_reqcyc); end
        serveFill(8'hA0, 0, 8'h00, 8, rq, tg, hsOk, early, ap, aa);
        vectors++; if (rq !== 64'h1000) begin miscompares++; $display("FAIL cold_mem_req: got %h want 1000", rq); end
        vectors++; if (tg !== 10'h380) begin miscompares++; $display("FAIL cold_mem_reqtag: got %h want 380", tg); end
        vectors++; if (hsOk !== 1'b1) begin miscompares++; $display("FAIL cold_handshake: got %b want 1", hsOk); end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL cold_early_resp: got %b want 0", early); end
        vectors++; if (ap !== 1'b1) begin miscompares++; $display("FAIL cold_respack_pulse: got %b want 1", ap); end
        vectors++; if (aa !== 1'b1) begin miscompares++; $display("FAIL cold_respack_single: got %b want 1", aa); end
        finishResp(data, cyc);
        vectors++; if (data !== 64'hA1) begin miscompares++; $display("FAIL cold_resp: got %h want a1", data); end
        vectors++; if (core_respcyc !== 1'b0) begin miscompares++; $display("FAIL cold_respcyc_drop: got %b want 0", core_respcyc); end
    endtask

    task automatic test_hit;
        int cyc;
        logic [63:0] data;
        startRead(64'h1038, cyc);
        vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL hit_reqack_latency: got %0d want 1", cyc); end
        vectors++; if (core_respcyc !== 1'b0) begin miscompares++; $display("FAIL hit_respcyc_early: got %b want 0", core_respcyc); end
        @(negedge clk);
        vectors++; if (core_respcyc !== 1'b1) begin miscompares++; $display("FAIL hit_respcyc_latency: got %b want 1", core_respcyc); end
        vectors++; if (mem_reqcyc !== 1'b0) begin miscompares++; $display("FAIL hit_no_mem_req: got %b want 0", mem_reqcyc); end
        finishResp(data, cyc);
        vectors++; if (data !== 64'hA7) begin miscompares++; $display("FAIL hit_resp: got %h want a7", data); end
    endtask

    task automatic test_conflict;
        int cyc;
        logic [63:0] rq, data;
        logic [9:0] tg;
        logic hsOk, early, ap, aa;
        startRead(64'h2010, cyc);
        @(negedge clk);
        vectors++; if (mem_reqcyc !== 1'b1) begin miscompares++; $display("FAIL conflict_miss: got %b want 1", mem_reqcyc); end
        serveFill(8'hB0, 0, 8'h00, 8, rq, tg, hsOk, early, ap, aa);
        vectors++; if (rq !== 64'h2000) begin miscompares++; $display("FAIL conflict_mem_req: got %h want 2000", rq); end
        finishResp(data, cyc);
        vectors++; if (data !== 64'hB2) begin miscompares++; $display("FAIL conflict_resp: got %h want b2", data); end
        startRead(64'h1000, cyc);
        @(negedge clk);
        vectors++; if (mem_reqcyc !== 1'b1) begin miscompares++; $display("FAIL evicted_miss: got %b want 1", mem_reqcyc); end
        serveFill(8'hC0, 0, 8'h00, 8, rq, tg, hsOk, early, ap, aa);
        vectors++; if (rq !== 64'h1000) begin miscompares++; $display("FAIL evicted_mem_req: got %h want 1000", rq); end
        finishResp(data, cyc);
        vectors++; if (data !== 64'hC0) begin miscompares++; $display("FAIL evicted_resp: got %h want c0", data); end
    endtask

    task automatic test_stalled_consumer;
        int cyc;
        logic [63:0] data;
        startRead(64'h1038, cyc);
        @(negedge clk);
        vectors++; if (core_respcyc !== 1'b1) begin miscompares++; $display("FAIL stall_respcyc: got %b want 1", core_respcyc); end
        core_req = 64'h1008;
        core_reqcyc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (core_respcyc !== 1'b1) begin miscompares++; $display("FAIL stall_respcyc_held[%0d]: got %b want 1", i, core_respcyc); end
            vectors++; if (core_resp !== 64'hC7) begin miscompares++; $display("FAIL stall_resp_stable[%0d]: got %h want c7", i, core_resp); end
            vectors++; if (core_reqack !== 1'b0) begin miscompares++; $display("FAIL stall_no_ack[%0d]: got %b want 0", i, core_reqack); end
        end
        core_respack = 1'b1;
        @(negedge clk);
        core_respack = 1'b0;
        vectors++; if (core_respcyc !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %b want 0", core_respcyc); end
        vectors++; if (core_reqack !== 1'b0) begin miscompares++; $display("FAIL stall_ack_in_respack: got %b want 0", core_reqack); end
        @(negedge clk);
        vectors++; if (core_reqack !== 1'b1) begin miscompares++; $display("FAIL stall_ack_next_idle: got %b want 1", core_reqack); end
        core_reqcyc = 1'b0;
        finishResp(data, cyc);
        vectors++; if (data !== 64'hC1) begin miscompares++; $display("FAIL stall_followup_resp: got %h want c1", data); end
    endtask

    task automatic test_gapped_fill;
        int cyc;
        logic [63:0] rq, data;
        logic [9:0] tg;
        logic hsOk, early, ap, aa;
        logic [63:0] hitAddr [3];
        logic [63:0] hitWant [3];
        hitAddr[0] = 64'h5040; hitWant[0] = 64'hD0;
        hitAddr[1] = 64'h5078; hitWant[1] = 64'hD7;
        hitAddr[2] = 64'h5050; hitWant[2] = 64'hD2;
        startRead(64'h5068, cyc);
        @(negedge clk);
        serveFill(8'hD0, 3, 8'b1010_0101, 8, rq, tg, hsOk, early, ap, aa);
        vectors++; if (rq !== 64'h5040) begin miscompares++; $display("FAIL gap_mem_req: got %h want 5040", rq); end
        vectors++; if (hsOk !== 1'b1) begin miscompares++; $display("FAIL gap_reqcyc_held: got %b want 1", hsOk); end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL gap_early_resp: got %b want 0", early); end
        vectors++; if (ap !== 1'b1) begin miscompares++; $display("FAIL gap_respack_pulse: got %b want 1", ap); end
        finishResp(data, cyc);
        vectors++; if (data !== 64'hD5) begin miscompares++; $display("FAIL gap_resp: got %h want d5", data); end
        for (int i = 0; i < 3; i++) begin
            startRead(hitAddr[i], cyc);
            @(negedge clk);
            vectors++; if (mem_reqcyc !== 1'b0) begin miscompares++; $display("FAIL gap_hit_no_miss[%0d]: got %b want 0", i, mem_reqcyc); end
            finishResp(data, cyc);
            vectors++; if (data !== hitWant[i]) begin miscompares++; $display("FAIL gap_hit_resp[%0d]: got %h want %h", i, data, hitWant[i]); end
        end
    endtask

    task automatic test_reset_mid_fill;
        int cyc;
        logic [63:0] rq, data;
        logic [9:0] tg;
        logic hsOk, early, ap, aa;
        startRead(64'h7090, cyc);
        @(negedge clk);
        serveFill(8'hE0, 0, 8'h00, 4, rq, tg, hsOk, early, ap, aa);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (core_respcyc !== 1'b0) begin miscompares++; $display("FAIL midrst_respcyc: got %b want 0", core_respcyc); end
        vectors++; if (core_resp !== 64'h0) begin miscompares++; $display("FAIL midrst_resp: got %h want 0", core_resp); end
        vectors++; if (mem_reqcyc !== 1'b0) begin miscompares++; $display("FAIL midrst_mem_reqcyc: got %b want 0", mem_reqcyc); end
        vectors++; if (mem_respack !== 1'b0) begin miscompares++; $display("FAIL midrst_mem_respack: got %b want 0", mem_respack); end
        reset = 1'b1;
        @(negedge clk);
        startRead(64'h7090, cyc);
        @(negedge clk);
        vectors++; if (mem_reqcyc !== 1'b1) begin miscompares++; $display("FAIL midrst_refill_miss: got %b want 1", mem_reqcyc); end
        serveFill(8'hF0, 0, 8'h00, 8, rq, tg, hsOk, early, ap, aa);
        vectors++; if (rq !== 64'h7080) begin miscompares++; $display("FAIL midrst_mem_req: got %h want 7080", rq); end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL midrst_early_resp: got %b want 0", early); end
        finishResp(data, cyc);
        vectors++; if (data !== 64'hF2) begin miscompares++; $display("FAIL midrst_resp: got %h want f2", data); end
        startRead(64'h5040, cyc);
        @(negedge clk);
        vectors++; if (mem_reqcyc !== 1'b1) begin miscompares++; $display("FAIL midrst_valid_cleared: got %b want 1", mem_reqcyc); end
        serveFill(8'hD0, 0, 8'h00, 8, rq, tg, hsOk, early, ap, aa);
        finishResp(data, cyc);
        vectors++; if (data !== 64'hD0) begin miscompares++; $display("FAIL midrst_other_resp: got %h want d0", data); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_stalled_consumer();
        test_gapped_fill();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
